// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - word-addressed data memory with fixed-latency request/response handshake
module data_memory_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_writedata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_readdata,
    output logic        resp_error,
    output logic [15:0] err_count
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_write;
    logic [31:0] mem [0:DEPTH_WORDS-1];

    logic             accept;
    logic             go_resp;
    logic [31:0]      op_addr;
    logic [31:0]      op_wdata;
    logic             op_write;
    logic [31:0]      offset;
    logic             op_error;
    logic [IDX_W-1:0] op_index;
    logic             mem_we;

    assign req_ready  = !reset && (state != WAIT);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    // The access is performed on the edge entering RESP. With no wait cycles that
    // is the accept edge itself, so the live request is used; otherwise the latched one.
    assign go_resp  = !reset && ((accept && (WAIT_CYCLES == 0)) ||
                                 ((state == WAIT) && (wait_cnt == 4'd0)));
    assign op_addr  = (state == WAIT) ? lat_addr  : req_addr;
    assign op_wdata = (state == WAIT) ? lat_wdata : req_writedata;
    assign op_write = (state == WAIT) ? lat_write : req_write;

    // Subtracting the base first lets a single unsigned compare catch both below-base
    // (wraps to a huge offset) and above-top addresses.
    assign offset   = op_addr - BASE_ADDR;
    assign op_error = (op_addr[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
    assign op_index = offset[IDX_W+1:2];
    assign mem_we   = go_resp && op_write && !op_error;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept from IDLE or RESP, count down in WAIT
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Wait counter: loaded on accept into WAIT, decremented while waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (accept && (state_nxt == WAIT)) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Request capture for the delayed access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_write <= 1'b0;
        end else if (accept) begin
            lat_addr  <= req_addr;
            lat_wdata <= req_writedata;
            lat_write <= req_write;
        end
    end

    // Response data, error flag and saturating error counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_readdata <= 32'd0;
            resp_error    <= 1'b0;
            err_count     <= 16'd0;
        end else begin
            resp_readdata <= (go_resp && !op_error && !op_write) ? mem[op_index] : 32'd0;
            resp_error    <= go_resp && op_error;
            if (go_resp && op_error && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    // Storage array; deliberately not reset so contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[op_index] <= op_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - randomized and directed bench for data_memory_responder
module tb_data_memory_responder;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst = '1;
    logic [N-1:0] vld = '0;
    logic [N-1:0] wr  = '0;
    logic [31:0]  addr  [N] = '{default: 32'd0};
    logic [31:0]  wdata [N] = '{default: 32'd0};
    logic [N-1:0] rdy;
    logic [N-1:0] rv;
    logic [N-1:0] rerr;
    logic [31:0]  rdata [N];
    logic [15:0]  ecnt  [N];

    int          wc_t    [N] = '{0, 3, 2};
    int          depth_t [N] = '{1024, 16, 16};
    logic [31:0] base_t  [N] = '{32'h0000_0000, 32'h0000_1000, 32'h8000_0040};

    int n_cmp = 0;
    int n_bad = 0;

    data_memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(vld[0]), .req_write(wr[0]), .req_addr(addr[0]),
        .req_writedata(wdata[0]), .req_ready(rdy[0]), .resp_valid(rv[0]), .resp_readdata(rdata[0]),
        .resp_error(rerr[0]), .err_count(ecnt[0]));
    data_memory_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .reset(rst[1]), .req_valid(vld[1]), .req_write(wr[1]), .req_addr(addr[1]),
        .req_writedata(wdata[1]), .req_ready(rdy[1]), .resp_valid(rv[1]), .resp_readdata(rdata[1]),
        .resp_error(rerr[1]), .err_count(ecnt[1]));
    data_memory_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h8000_0040), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(rst[2]), .req_valid(vld[2]), .req_write(wr[2]), .req_addr(addr[2]),
        .req_writedata(wdata[2]), .req_ready(rdy[2]), .resp_valid(rv[2]), .resp_readdata(rdata[2]),
        .resp_error(rerr[2]), .err_count(ecnt[2]));

    // Reference model: one outstanding access per instance, due a fixed number of edges after accept
    bit          pend   [N] = '{default: 1'b0};
    longint      due    [N] = '{default: 0};
    logic [31:0] p_addr [N];
    logic [31:0] p_data [N];
    bit          p_wr   [N];
    bit          ev     [N] = '{default: 1'b0};
    bit          er     [N] = '{default: 1'b0};
    bit          ek     [N] = '{default: 1'b1};
    logic [31:0] ed     [N] = '{default: 32'd0};
    int          errc   [N] = '{default: 0};
    bit          macc   [N] = '{default: 1'b0};
    logic [31:0] mmem   [N][1024];
    bit          mknown [N][1024];
    longint      cyc = 0;

    function automatic void execute(int i, logic [31:0] a, bit w, logic [31:0] d);
        longint off = longint'(a) - longint'(base_t[i]);
        bit bad = (a % 4 != 0) || (off < 0) || (off >= longint'(depth_t[i]) * 4);
        ev[i] = 1'b1;
        er[i] = bad;
        ed[i] = 32'd0;
        ek[i] = 1'b1;
        if (bad) begin
            if (errc[i] < 65535) errc[i] = errc[i] + 1;
        end else if (w) begin
            mmem[i][off / 4]   = d;
            mknown[i][off / 4] = 1'b1;
        end else begin
            ed[i] = mmem[i][off / 4];
            ek[i] = mknown[i][off / 4];
        end
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            macc[i] = 1'b0;
            ev[i] = 1'b0; er[i] = 1'b0; ed[i] = 32'd0; ek[i] = 1'b1;
            if (rst[i]) begin
                pend[i] = 1'b0;
                errc[i] = 0;
            end else if (pend[i]) begin
                if (cyc == due[i]) begin
                    execute(i, p_addr[i], p_wr[i], p_data[i]);
                    pend[i] = 1'b0;
                end
            end else if (vld[i]) begin
                macc[i] = 1'b1;
                if (wc_t[i] == 0) begin
                    execute(i, addr[i], wr[i], wdata[i]);
                end else begin
                    pend[i]   = 1'b1;
                    due[i]    = cyc + wc_t[i];
                    p_addr[i] = addr[i];
                    p_data[i] = wdata[i];
                    p_wr[i]   = wr[i];
                end
            end
        end
        cyc = cyc + 1;
    end

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk(i, "req_ready", {31'd0, rdy[i]}, {31'd0, !rst[i] && !pend[i]});
            chk(i, "resp_valid", {31'd0, rv[i]}, {31'd0, !rst[i] && ev[i]});
            chk(i, "resp_error", {31'd0, rerr[i]}, {31'd0, !rst[i] && er[i]});
            chk(i, "err_count", {16'd0, ecnt[i]}, rst[i] ? 32'd0 : 32'(errc[i]));
            if (rst[i] || ek[i]) chk(i, "resp_readdata", rdata[i], rst[i] ? 32'd0 : ed[i]);
        end
    end

    task automatic access(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit got = 1'b0;
        vld[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d;
        for (int k = 0; k < 64 && !got; k++) begin
            @(posedge clk); #1;
            got = macc[i];
        end
        vld[i] = 1'b0;
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout inst%0d addr %h", i, a);
        end
    endtask

    task automatic wait_resp(input int i);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = rv[i];
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL resp_timeout inst%0d", i);
        end
    endtask

    task automatic do_reset(input int i);
        @(posedge clk); #1 rst[i] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst[i] = 1'b0;
    endtask

    task automatic fill(input int i, input int nw);
        for (int w = 0; w < nw; w++) access(i, 1'b1, base_t[i] + 32'(4 * w), $urandom);
    endtask

    task automatic rand_run(input int i, input int n);
        int nw = (i == 0) ? 32 : 16;
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            int sel;
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            a = base_t[i] + 32'(4 * $urandom_range(0, nw - 1));
            sel = $urandom_range(0, 15);
            if (sel == 0)      a = a | 32'($urandom_range(1, 3));
            else if (sel == 1) a = base_t[i] - 32'd4;
            else if (sel == 2) a = base_t[i] + 32'(depth_t[i] * 4);
            else if (sel == 3) a = $urandom;
            access(i, 1'($urandom_range(0, 1)), a, $urandom);
        end
    endtask

    initial begin
        @(negedge clk);
        chk(0, "reset_ready", {31'd0, rdy[0]}, 32'd0);
        chk(0, "reset_valid", {31'd0, rv[0]}, 32'd0);
        chk(0, "reset_err_count", {16'd0, ecnt[0]}, 32'd0);
        @(posedge clk); #1 rst = '0;
        @(negedge clk);
        chk(0, "ready_after_reset", {31'd0, rdy[0]}, 32'd1);

        fork
            fill(0, 32);
            fill(1, 16);
            fill(2, 16);
        join

        // back-to-back store then load at one access per cycle
        access(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk(0, "store_resp_valid", {31'd0, rv[0]}, 32'd1);
        access(0, 1'b0, 32'h10, 32'd0);
        @(negedge clk);
        chk(0, "load_resp_valid", {31'd0, rv[0]}, 32'd1);
        chk(0, "load_readdata", rdata[0], 32'hDEAD_BEEF);
        chk(0, "load_error", {31'd0, rerr[0]}, 32'd0);

        // top-of-array boundary
        access(0, 1'b0, 32'h1000, 32'd0);
        wait_resp(0);
        chk(0, "oob_error", {31'd0, rerr[0]}, 32'd1);
        chk(0, "oob_readdata", rdata[0], 32'd0);
        access(0, 1'b1, 32'hFFC, 32'hA5A5_0FFC);
        access(0, 1'b0, 32'hFFC, 32'd0);
        wait_resp(0);
        chk(0, "top_word_error", {31'd0, rerr[0]}, 32'd0);
        chk(0, "top_word_readdata", rdata[0], 32'hA5A5_0FFC);

        // three wait cycles: ready low three cycles, single response pulse after
        access(1, 1'b0, 32'h1000, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(1, "wait_ready_low", {31'd0, rdy[1]}, 32'd0);
            chk(1, "wait_no_valid", {31'd0, rv[1]}, 32'd0);
        end
        @(negedge clk);
        chk(1, "wait_resp_valid", {31'd0, rv[1]}, 32'd1);
        @(negedge clk);
        chk(1, "wait_resp_pulse", {31'd0, rv[1]}, 32'd0);

        // misaligned store is rejected and leaves the word intact
        do_reset(1);
        access(1, 1'b1, 32'h1010, 32'h1234_5678);
        wait_resp(1);
        access(1, 1'b1, 32'h1012, 32'hFFFF_FFFF);
        wait_resp(1);
        chk(1, "misaligned_error", {31'd0, rerr[1]}, 32'd1);
        chk(1, "misaligned_readdata", rdata[1], 32'd0);
        access(1, 1'b0, 32'h1010, 32'd0);
        wait_resp(1);
        chk(1, "word_unchanged", rdata[1], 32'h1234_5678);
        chk(1, "misaligned_err_count", {16'd0, ecnt[1]}, 32'd1);

        // reset during WAIT drops the store
        access(2, 1'b1, 32'h8000_0048, 32'h0BAD_F00D);
        wait_resp(2);
        access(2, 1'b1, 32'h8000_0048, 32'h5555_AAAA);
        rst[2] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk(2, "dropped_no_resp", {31'd0, rv[2]}, 32'd0);
        end
        @(posedge clk); #1 rst[2] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk(2, "dropped_no_resp", {31'd0, rv[2]}, 32'd0);
        end
        access(2, 1'b0, 32'h8000_0048, 32'd0);
        wait_resp(2);
        chk(2, "dropped_store_value", rdata[2], 32'h0BAD_F00D);
        chk(2, "dropped_err_count", {16'd0, ecnt[2]}, 32'd0);

        fork
            rand_run(0, 600);
            rand_run(1, 600);
            rand_run(2, 600);
        join

        // error counter saturation
        do_reset(0);
        repeat (65535) access(0, 1'b0, 32'h2, 32'd0);
        @(negedge clk);
        chk(0, "err_count_full", {16'd0, ecnt[0]}, 32'h0000_FFFF);
        access(0, 1'b1, 32'h3, 32'h1);
        @(negedge clk);
        chk(0, "err_count_saturated", {16'd0, ecnt[0]}, 32'h0000_FFFF);
        chk(0, "err_after_sat", {31'd0, rerr[0]}, 32'd1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
